// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// mdu_op_e encodes funct3 and is also used by the control decoder.
// mdu_state_e is the sequencer state. Helper functions classify the operations.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_rs1_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_rs2_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential RV32/64 M-extension unit. It performs radix-2 shift-add multiply
// and restoring divide, one iteration per clock.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   request handshake (funct3, rs1, rs2, tag_in)
//   flush               aborts any in-flight op and blocks acceptance
//   out_valid/out_ready result handshake (result, tag_out)
//   busy                high whenever the unit is not idle
module muldiv_seq
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [TAGW-1:0] tag_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAGW-1:0]   tag_q, tag_d;

  // Request decode
  mdu_op_e         op_in;
  logic            accept, sa, sb, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in    = mdu_op_e'(funct3);
  assign accept   = in_valid && (state_q == ST_IDLE) && !flush;
  assign sa       = rs1[XLEN-1] & op_rs1_signed(op_in);
  assign sb       = rs2[XLEN-1] & op_rs2_signed(op_in);
  assign mag_a    = sa ? -rs1 : rs1;
  assign mag_b    = sb ? -rs2 : rs2;
  assign div_zero = op_is_div(op_in) && (rs2 == '0);
  assign ovf      = (op_in inside {OP_DIV, OP_REM}) && (rs1 == MOST_NEG) && (rs2 == '1);

  // One iteration. Multiply consumes the multiplier from the low half while
  // the product grows in from the top. Divide shifts the dividend out of the
  // low half as quotient bits shift in, and the partial remainder sits in the
  // high half.
  logic [XLEN:0]     mul_sum, div_shl, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod;
  logic [XLEN-1:0]   quo, rem_v, fin;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shl  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_shl - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign step_acc = op_is_div(op_q) ? div_next : mul_next;

  assign prod  = neg_q ? -step_acc : step_acc;
  assign quo   = step_acc[XLEN-1:0];
  assign rem_v = step_acc[2*XLEN-1:XLEN];

  always_comb begin
    fin = '0;
    if (!op_is_div(op_q)) begin
      fin = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (op_is_rem(op_q)) begin
      fin = neg_q ? -rem_v : rem_v;
    end else begin
      fin = neg_q ? -quo : quo;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    tag_d   = tag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          // A remainder takes the dividend's sign. Every other result takes the XOR of both signs.
          neg_d = op_is_rem(op_in) ? sa : (sa ^ sb);
          b_d   = mag_b;
          tag_d = tag_in;
          if (div_zero) begin
            res_d   = op_is_rem(op_in) ? rs1 : '1;
            state_d = ST_DONE;
          end else if (ovf) begin
            res_d   = op_is_rem(op_in) ? '0 : rs1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            cnt_d   = CW'(XLEN - 1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            res_d   = fin;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = res_q;
  assign tag_out   = tag_q;

endmodule
